// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: store-size codes and FSM states.
package mem_arbiter_pkg;

  localparam logic [1:0] MEM_READ = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin picker: one-hot pick from req, priority flips to the other requester on update.
module arb_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] pick
);

  logic favour_loader;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = favour_loader ? 2'b10 : 2'b01;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      favour_loader <= 1'b0;
    end else if (update) begin
      favour_loader <= pick[0];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU (bit 0) and a loader/debug port (bit 1) onto one memory port.
// Optional ack-wait timer is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  arb_state_t  state, state_next;
  logic [1:0]  pick;
  logic [1:0]  win;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        start;
  logic        expire;

  assign start = (state == IDLE) && (req != 2'b00);

  // The timer is 8 bits wide, so only 1..255 is a meaningful limit.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
  end

  arb_rr2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (start),
    .pick   (pick)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] timer;
  logic       err_q;

  // A same-cycle ack wins over the limit, hence the !mem_ack term.
  assign expire = (state == ACCESS) && !mem_ack && (timer == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (start) begin
        timer <= 8'd0;
      end else if (state == ACCESS && !mem_ack) begin
        timer <= timer + 8'd1;
      end
      if (state == ACCESS && (mem_ack || expire)) begin
        err_q <= !mem_ack;
      end
    end
  end

  assign err = (state == RESP) && err_q;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS:  if (mem_ack || expire) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win     <= 2'b00;
      size_q  <= MEM_READ;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (start) begin
        win     <= pick;
        size_q  <= pick[1] ? size1 : size0;
        addr_q  <= pick[1] ? addr1 : addr0;
        wdata_q <= pick[1] ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        if (mem_ack) begin
          rdata_q <= mem_rdata;
        end else if (expire) begin
          rdata_q <= 32'd0;
        end
      end
    end
  end

  // Command outputs decode from state, so an async reset drops mem_en in the same cycle.
  assign gnt       = (state != IDLE) ? win : 2'b00;
  assign done      = (state == RESP) ? win : 2'b00;
  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) ? size_q : MEM_READ;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule
